// File: rtl/sd_pkg.sv
// Shared SD/SPI types, defaults and helpers.
package sd_pkg;

  localparam int unsigned SD_DIV_SLOW = 63;
  localparam int unsigned SD_DIV_FAST = 1;
  localparam int unsigned SD_CNT_W    = 6;
  localparam int unsigned SD_WORD_W   = 32;
  localparam int unsigned SD_BITCNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_DONE     = 2'd3
  } sd_spi_state_e;

  typedef enum logic [1:0] {
    SD_LEN_1B = 2'd0,
    SD_LEN_2B = 2'd1,
    SD_LEN_3B = 2'd2,
    SD_LEN_4B = 2'd3
  } sd_len_e;

  // Bit count for a len code: 8 * (len + 1).
  function automatic logic [SD_BITCNT_W-1:0] sd_len_bits(input logic [1:0] len);
    logic [SD_BITCNT_W-1:0] w_bits;
    w_bits = {1'b0, len, 3'b000} + SD_BITCNT_W'(8);
    return w_bits;
  endfunction

endpackage

// File: rtl/sd_spi_phy_if.sv
// Word port from the SD controller plus the SPI pins toward the card.
interface sd_spi_phy_if;
  import sd_pkg::*;

  logic                 begin_req;
  logic [SD_WORD_W-1:0] mosi_word;
  logic [1:0]           len;
  logic                 fast_mode;
  logic                 cs_assert;
  logic                 busy;
  logic [SD_WORD_W-1:0] miso_word;
  logic                 sck;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;

  // Controller side (also drives the card's miso line in loopback setups).
  modport master (
    output begin_req, mosi_word, len, fast_mode, cs_assert, miso,
    input  busy, miso_word, sck, cs_n, mosi
  );

  // PHY side.
  modport slave (
    input  begin_req, mosi_word, len, fast_mode, cs_assert, miso,
    output busy, miso_word, sck, cs_n, mosi
  );

endinterface

// File: rtl/sd_spi_clkgen.sv
// Half-period counter: strobes at the end of each SCK half-period.
module sd_spi_clkgen #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_phase_hi,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_rise_c,
  output logic             o_fall_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick   = i_en && (r_cnt == (i_div - CNT_W'(1)));
  assign o_rise_c = w_tick && !i_phase_hi;
  assign o_fall_c = w_tick &&  i_phase_hi;

  // Count 0..D-1, reload at every SCK edge and while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sd_spi_phy.sv
// Byte-serial SPI mode-0 master serving the SD controller's word port.
module sd_spi_phy
  import sd_pkg::*;
#(
  parameter int unsigned DIV_SLOW = SD_DIV_SLOW,
  parameter int unsigned DIV_FAST = SD_DIV_FAST,
  parameter int unsigned CNT_W    = SD_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  sd_spi_phy_if.slave  bus
);

  sd_spi_state_e          r_state;
  sd_spi_state_e          w_state_nxt;

  logic                   r_busy,      w_busy_nxt;
  logic                   r_sck,       w_sck_nxt;
  logic                   r_cs_n,      w_cs_n_nxt;
  logic                   r_mosi,      w_mosi_nxt;
  logic [SD_WORD_W-1:0]   r_miso_word, w_miso_word_nxt;
  logic [SD_WORD_W-1:0]   r_tx,        w_tx_nxt;
  logic [SD_WORD_W-1:0]   r_rx,        w_rx_nxt;
  logic [SD_BITCNT_W-1:0] r_bitcnt,    w_bitcnt_nxt;
  logic [CNT_W-1:0]       r_div,       w_div_nxt;

  logic                   w_rise;
  logic                   w_fall;
  logic                   w_shift_en;
  logic                   w_last_bit;
  logic [SD_WORD_W-1:0]   w_tx_load;

  // Left-align the request so the first bit to send is always tx[31].
  assign w_tx_load  = bus.mosi_word << {~bus.len, 3'b000};
  assign w_shift_en = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);
  assign w_last_bit = (r_bitcnt == SD_BITCNT_W'(1));

  sd_spi_clkgen #(
    .CNT_W (CNT_W)
  ) u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_shift_en),
    .i_phase_hi (r_state == ST_SHIFT_HI),
    .i_div      (r_div),
    .o_rise_c   (w_rise),
    .o_fall_c   (w_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (bus.begin_req) w_state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_rise)        w_state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_fall)        w_state_nxt = w_last_bit ? ST_DONE : ST_SHIFT_LO;
      ST_DONE:                        w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; every register holds unless updated below.
  always_comb begin
    w_busy_nxt      = r_busy;
    w_sck_nxt       = r_sck;
    w_cs_n_nxt      = r_cs_n;
    w_mosi_nxt      = r_mosi;
    w_miso_word_nxt = r_miso_word;
    w_tx_nxt        = r_tx;
    w_rx_nxt        = r_rx;
    w_bitcnt_nxt    = r_bitcnt;
    w_div_nxt       = r_div;
    case (r_state)
      ST_IDLE: begin
        w_cs_n_nxt = ~bus.cs_assert;
        if (bus.begin_req) begin
          w_busy_nxt   = 1'b1;
          w_sck_nxt    = 1'b0;
          w_tx_nxt     = w_tx_load;
          w_mosi_nxt   = w_tx_load[SD_WORD_W-1];
          w_rx_nxt     = '0;
          w_bitcnt_nxt = sd_len_bits(bus.len);
          w_div_nxt    = bus.fast_mode ? CNT_W'(DIV_FAST) : CNT_W'(DIV_SLOW);
        end
      end
      ST_SHIFT_LO: begin
        if (w_rise) begin
          w_sck_nxt = 1'b1;
          w_rx_nxt  = {r_rx[SD_WORD_W-2:0], bus.miso};
        end
      end
      ST_SHIFT_HI: begin
        if (w_fall) begin
          w_sck_nxt    = 1'b0;
          w_bitcnt_nxt = r_bitcnt - SD_BITCNT_W'(1);
          if (w_last_bit) begin
            w_busy_nxt      = 1'b0;
            w_mosi_nxt      = 1'b1;
            w_miso_word_nxt = r_rx;
          end else begin
            w_tx_nxt   = {r_tx[SD_WORD_W-2:0], 1'b0};
            w_mosi_nxt = r_tx[SD_WORD_W-2];
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output/datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b1;
      r_miso_word <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bitcnt    <= '0;
      r_div       <= CNT_W'(DIV_SLOW);
    end else begin
      r_busy      <= w_busy_nxt;
      r_sck       <= w_sck_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_miso_word <= w_miso_word_nxt;
      r_tx        <= w_tx_nxt;
      r_rx        <= w_rx_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_div       <= w_div_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.sck       = r_sck;
  assign bus.cs_n      = r_cs_n;
  assign bus.mosi      = r_mosi;
  assign bus.miso_word = r_miso_word;

endmodule
